// File: rtl/seq_window_checker_if.sv
// Signal bundle between a sequence window checker and its driver/observer.
// The driver controls enable/clear and the stimulus; the checker returns status and counters.
interface seq_window_checker_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) ();
  logic              en;
  logic              clr;
  logic [NUM_CH-1:0] a;
  logic [NUM_CH-1:0] b;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] pass_pulse;
  logic [NUM_CH-1:0] fail_pulse;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;

  modport master (
    output en, clr, a, b,
    input  busy, pass_pulse, fail_pulse, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, clr, a, b,
    output busy, pass_pulse, fail_pulse, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/seq_window_checker.sv
// Multi-channel "a ##[MIN_DLY:MAX_DLY] b" monitor.
// Each channel has its own window FSM. Pass/fail decisions are registered pulses feeding saturating totals.
module seq_window_checker #(
  parameter int NUM_CH       = 4,
  parameter int MIN_DLY      = 1,
  parameter int MAX_DLY      = 4,
  parameter int STRICT_EARLY = 0,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst,
  seq_window_checker_if.slave bus
);

  if (NUM_CH < 1 || MIN_DLY < 1 || MAX_DLY < MIN_DLY) begin : g_param_check
    $error("seq_window_checker: requires NUM_CH>=1, MIN_DLY>=1 and MAX_DLY>=MIN_DLY");
  end

  localparam int TW = $clog2(MAX_DLY + 1);
  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = CNT_W + PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    WINDOW = 2'd2
  } state_t;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [TW-1:0]     timer_q [NUM_CH];
  logic [TW-1:0]     timer_d [NUM_CH];
  logic [NUM_CH-1:0] pass_d, fail_d;
  logic [NUM_CH-1:0] pass_q, fail_q;
  logic [NUM_CH-1:0] busy;
  logic [CNT_W-1:0]  pass_cnt_q, fail_cnt_q;
  logic [CNT_W-1:0]  pass_cnt_d, fail_cnt_d;
  logic [SW-1:0]     pass_sum, fail_sum;

  function automatic logic [PW-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  // Per-channel window tracking; the timer holds the current offset from the antecedent.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      pass_d[i]  = 1'b0;
      fail_d[i]  = 1'b0;
      if (!bus.en) begin
        state_d[i] = IDLE;
        timer_d[i] = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (bus.a[i]) begin
              timer_d[i] = TW'(1);
              state_d[i] = (MIN_DLY == 1) ? WINDOW : WAIT;
            end
          end
          WAIT: begin
            if (STRICT_EARLY != 0 && bus.b[i]) begin
              fail_d[i]  = 1'b1;
              state_d[i] = IDLE;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + TW'(1);
              if (timer_q[i] == TW'(MIN_DLY - 1)) state_d[i] = WINDOW;
            end
          end
          WINDOW: begin
            // A consequent on the last allowed offset still counts as a pass.
            if (bus.b[i]) begin
              pass_d[i]  = 1'b1;
              state_d[i] = IDLE;
              timer_d[i] = '0;
            end else if (timer_q[i] == TW'(MAX_DLY)) begin
              fail_d[i]  = 1'b1;
              state_d[i] = IDLE;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + TW'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Totals saturate instead of wrapping; clear wins over a same-cycle increment.
  always_comb begin
    pass_sum   = SW'(pass_cnt_q) + SW'(popcount(pass_d));
    fail_sum   = SW'(fail_cnt_q) + SW'(popcount(fail_d));
    pass_cnt_d = (|pass_sum[SW-1:CNT_W]) ? '1 : pass_sum[CNT_W-1:0];
    fail_cnt_d = (|fail_sum[SW-1:CNT_W]) ? '1 : fail_sum[CNT_W-1:0];
    if (bus.clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
      pass_q     <= '0;
      fail_q     <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] != IDLE);
    end
  end

  assign bus.busy       = busy;
  assign bus.pass_pulse = pass_q;
  assign bus.fail_pulse = fail_q;
  assign bus.pass_cnt   = pass_cnt_q;
  assign bus.fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_seq_window_checker.sv
// Scoreboard bench for seq_window_checker (MIN_DLY=2, MAX_DLY=4, 4 channels, 8-bit counters).
// A second instance with STRICT_EARLY=1 covers early-consequent failure.
module tb_seq_window_checker;

  localparam int NUM_CH  = 4;
  localparam int MIN_DLY = 2;
  localparam int MAX_DLY = 4;
  localparam int CNT_W   = 8;

  typedef struct {
    int         edge_no;
    logic [3:0] pass;
    logic [3:0] fail;
    logic [7:0] pcnt;
    logic [7:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   exp_pcnt;
  int   exp_fcnt;
  logic drive_strict;
  exp_t sb_q[$];

  seq_window_checker_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  seq_window_checker_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) sbus ();

  seq_window_checker #(
    .NUM_CH(NUM_CH), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .STRICT_EARLY(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  seq_window_checker #(
    .NUM_CH(NUM_CH), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .STRICT_EARLY(1), .CNT_W(CNT_W)
  ) dut_strict (
    .clk(clk),
    .rst(rst),
    .bus(sbus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Present inputs for the next rising edge, then return 1 ns after it.
  task automatic apply_stimulus(input logic [3:0] a_v, input logic [3:0] b_v);
    bus.a  = a_v;
    bus.b  = b_v;
    sbus.a = drive_strict ? a_v : 4'b0;
    sbus.b = drive_strict ? b_v : 4'b0;
    @(posedge clk);
    #1;
  endtask

  // Call just before the apply_stimulus whose edge makes the decision.
  task automatic expect_event(input logic [3:0] p, input logic [3:0] f);
    exp_t e;
    if (bus.clr) begin
      exp_pcnt = 0;
      exp_fcnt = 0;
    end else begin
      exp_pcnt = exp_pcnt + $countones(p);
      exp_fcnt = exp_fcnt + $countones(f);
      if (exp_pcnt > 255) exp_pcnt = 255;
      if (exp_fcnt > 255) exp_fcnt = 255;
    end
    e.edge_no = cyc + 1;
    e.pass    = p;
    e.fail    = f;
    e.pcnt    = 8'(exp_pcnt);
    e.fcnt    = 8'(exp_fcnt);
    sb_q.push_back(e);
  endtask

  // Any pulse must match the oldest expected decision, including when it happened.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((bus.pass_pulse | bus.fail_pulse) != 4'b0)) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_pulse: got pass=%b fail=%b, expected none (edge %0d)",
                 bus.pass_pulse, bus.fail_pulse, cyc);
      end else begin
        e = sb_q.pop_front();
        check_output("pulse_edge", cyc, e.edge_no);
        check_output("pass_pulse", bus.pass_pulse, e.pass);
        check_output("fail_pulse", bus.fail_pulse, e.fail);
        check_output("pass_cnt", bus.pass_cnt, e.pcnt);
        check_output("fail_cnt", bus.fail_cnt, e.fcnt);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b1;  bus.clr = 1'b0;  bus.a = '0;  bus.b = '0;
    sbus.en = 1'b1; sbus.clr = 1'b0; sbus.a = '0; sbus.b = '0;
    drive_strict = 1'b0;
    exp_pcnt = 0;
    exp_fcnt = 0;

    #23;
    check_output("rst_busy", bus.busy, 4'b0);
    check_output("rst_pass_pulse", bus.pass_pulse, 4'b0);
    check_output("rst_fail_pulse", bus.fail_pulse, 4'b0);
    check_output("rst_pass_cnt", bus.pass_cnt, 8'd0);
    check_output("rst_fail_cnt", bus.fail_cnt, 8'd0);
    rst = 1'b0;
    repeat (2) apply_stimulus(4'b0, 4'b0);

    $display("[TB] pass at offset 3");
    apply_stimulus(4'b0001, 4'b0);
    check_output("s1_busy_start", bus.busy, 4'b0001);
    apply_stimulus(4'b0, 4'b0);
    apply_stimulus(4'b0, 4'b0);
    check_output("s1_busy_mid", bus.busy, 4'b0001);
    expect_event(4'b0001, 4'b0);
    apply_stimulus(4'b0, 4'b0001);
    check_output("s1_busy_end", bus.busy, 4'b0);
    repeat (2) apply_stimulus(4'b0, 4'b0);

    $display("[TB] timeout fail, late consequent ignored");
    apply_stimulus(4'b0010, 4'b0);
    repeat (3) apply_stimulus(4'b0, 4'b0);
    expect_event(4'b0, 4'b0010);
    apply_stimulus(4'b0, 4'b0);
    apply_stimulus(4'b0, 4'b0010);
    check_output("s2_busy_after", bus.busy, 4'b0);
    repeat (2) apply_stimulus(4'b0, 4'b0);

    $display("[TB] early consequent, relaxed and strict");
    drive_strict = 1'b1;
    apply_stimulus(4'b0100, 4'b0);
    apply_stimulus(4'b0, 4'b0100);
    check_output("s3_strict_fail", sbus.fail_pulse, 4'b0100);
    check_output("s3_strict_busy", sbus.busy, 4'b0);
    check_output("s3_relaxed_busy", bus.busy, 4'b0100);
    expect_event(4'b0100, 4'b0);
    apply_stimulus(4'b0, 4'b0100);
    check_output("s3_strict_no_pass", sbus.pass_pulse, 4'b0);
    check_output("s3_strict_one_fail", sbus.fail_pulse, 4'b0);
    check_output("s3_strict_fail_cnt", sbus.fail_cnt, 8'd1);
    drive_strict = 1'b0;
    repeat (2) apply_stimulus(4'b0, 4'b0);

    $display("[TB] four-channel passes at MAX_DLY up to saturation");
    for (int n = 0; n < 65; n++) begin
      apply_stimulus(4'b1111, 4'b0);
      repeat (3) apply_stimulus(4'b0, 4'b0);
      expect_event(4'b1111, 4'b0);
      apply_stimulus(4'b0, 4'b1111);
    end
    check_output("s4_pass_cnt_sat", bus.pass_cnt, 8'hFF);
    apply_stimulus(4'b0, 4'b0);

    $display("[TB] re-trigger while busy");
    apply_stimulus(4'b1000, 4'b0);
    apply_stimulus(4'b1000, 4'b0);
    repeat (2) apply_stimulus(4'b0, 4'b0);
    expect_event(4'b0, 4'b1000);
    apply_stimulus(4'b1000, 4'b0);
    apply_stimulus(4'b0, 4'b0);
    check_output("s5_no_restart", bus.busy, 4'b0);
    repeat (5) apply_stimulus(4'b0, 4'b0);

    $display("[TB] asynchronous reset mid-attempt");
    apply_stimulus(4'b0001, 4'b0);
    #3;
    rst = 1'b1;
    #1;
    check_output("s6_busy_now", bus.busy, 4'b0);
    check_output("s6_pass_cnt_now", bus.pass_cnt, 8'd0);
    check_output("s6_fail_cnt_now", bus.fail_cnt, 8'd0);
    check_output("s6_strict_fail_cnt_now", sbus.fail_cnt, 8'd0);
    #1;
    rst = 1'b0;
    exp_pcnt = 0;
    exp_fcnt = 0;
    repeat (5) apply_stimulus(4'b0, 4'b0);
    check_output("s6_busy_after", bus.busy, 4'b0);

    $display("[TB] enable dropped mid-window");
    apply_stimulus(4'b0010, 4'b0);
    apply_stimulus(4'b0, 4'b0);
    apply_stimulus(4'b0, 4'b0);
    check_output("s7_busy_window", bus.busy, 4'b0010);
    bus.en = 1'b0;
    apply_stimulus(4'b0, 4'b0);
    check_output("s7_aborted", bus.busy, 4'b0);
    apply_stimulus(4'b0001, 4'b0);
    check_output("s7_no_start", bus.busy, 4'b0);
    bus.en = 1'b1;
    apply_stimulus(4'b0, 4'b0010);
    repeat (4) apply_stimulus(4'b0, 4'b0);

    $display("[TB] clear coincident with pass");
    apply_stimulus(4'b0011, 4'b0);
    apply_stimulus(4'b0, 4'b0);
    expect_event(4'b0001, 4'b0);
    apply_stimulus(4'b0, 4'b0001);
    apply_stimulus(4'b0, 4'b0);
    expect_event(4'b0, 4'b0010);
    apply_stimulus(4'b0, 4'b0);
    apply_stimulus(4'b0, 4'b0);
    apply_stimulus(4'b0001, 4'b0);
    apply_stimulus(4'b0, 4'b0);
    bus.clr = 1'b1;
    expect_event(4'b0001, 4'b0);
    apply_stimulus(4'b0, 4'b0001);
    bus.clr = 1'b0;
    check_output("s8_pass_cnt_cleared", bus.pass_cnt, 8'd0);
    check_output("s8_fail_cnt_cleared", bus.fail_cnt, 8'd0);
    apply_stimulus(4'b0001, 4'b0);
    apply_stimulus(4'b0, 4'b0);
    expect_event(4'b0001, 4'b0);
    apply_stimulus(4'b0, 4'b0001);

    repeat (4) apply_stimulus(4'b0, 4'b0);
    check_output("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
